// File: rtl/latch_bank_wr_ctrl.sv
// Write sequencer for a bank of level-sensitive D latches shared by NREQ requesters.
// Round-robin arbitration; registered one-hot enables with one setup and one hold cycle.
module latch_bank_wr_ctrl #(
  parameter int NREQ     = 4,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [(1<<AW)-1:0]   lat_en,
  output logic [DW-1:0]        lat_d,
  output logic                 busy
);

  // state | meaning
  // IDLE  | sample req, capture winner's addr/data
  // SETUP | data bus driven, enables closed
  // OPEN  | selected latch transparent for OPEN_CYC cycles
  // HOLD  | enables closed, data held, done pulse

  localparam int NW = 1 << AW;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (OPEN_CYC > 1) ? $clog2(OPEN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(OPEN_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_OPEN  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win_q;
  logic [AW-1:0] addr_q;
  logic [CW-1:0] cnt;

  logic          any_req;
  logic [PW-1:0] win;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic [PW:0]   sum;

  // First set request at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    any_req  = 1'b0;
    win      = '0;
    sum      = '0;
    win_addr = '0;
    win_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ))
        sum = sum - (PW+1)'(NREQ);
      if (!any_req && req[sum[PW-1:0]]) begin
        any_req = 1'b1;
        win     = sum[PW-1:0];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        win_addr = addr[i*AW +: AW];
        win_data = wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      win_q  <= '0;
      addr_q <= '0;
      cnt    <= '0;
      gnt    <= '0;
      done   <= '0;
      lat_en <= '0;
      lat_d  <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state  <= S_SETUP;
            win_q  <= win;
            addr_q <= win_addr;
            lat_d  <= win_data;
            gnt    <= NREQ'(1) << win;
            busy   <= 1'b1;
          end
        end
        S_SETUP: begin
          state  <= S_OPEN;
          lat_en <= NW'(1) << addr_q;
          cnt    <= CNT_LOAD;
        end
        S_OPEN: begin
          if (cnt == '0) begin
            state  <= S_HOLD;
            lat_en <= '0;
            done   <= NREQ'(1) << win_q;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          state  <= S_IDLE;
          gnt    <= '0;
          done   <= '0;
          busy   <= 1'b0;
          rr_ptr <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
